// File: rtl/uart_bus_master.sv
// Sequencing master for the UART configuration register bus: turns host byte/divisor
// commands into one- or two-cycle register bus accesses and returns a registered response.
module uart_bus_master #(
  parameter logic [2:0] STR_ADDR  = 3'd1,
  parameter logic [2:0] LDVR_ADDR = 3'd4,
  parameter logic [2:0] UDVR_ADDR = 3'd5,
  parameter logic [2:0] IDLE_ADDR = STR_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [2:0]  cmd_addr_i,
  input  logic [15:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_data_o,
  output logic        read_o,
  output logic        write_o,
  output logic [2:0]  address_o,
  inout  wire  [7:0]  data_io
);

  localparam logic [1:0] OP_WR_BYTE = 2'b00;
  localparam logic [1:0] OP_RD_BYTE = 2'b01;
  localparam logic [1:0] OP_WR_DIV  = 2'b10;
  localparam logic [1:0] OP_RD_DIV  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [7:0]  data_hi_q;
  logic [7:0]  rd_hi_q, rd_hi_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [2:0]  addr_q, addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        take_cmd;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= IDLE_ADDR;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Datapath bytes are only meaningful while the FSM qualifies them, so they carry no reset.
  always_ff @(posedge clk_i) begin
    wbyte_q <= wbyte_d;
    rd_hi_q <= rd_hi_d;
    if (take_cmd) begin
      op_q      <= cmd_op_i;
      data_hi_q <= cmd_data_i[15:8];
    end
  end

  always_comb begin
    state_d     = state_q;
    read_d      = 1'b0;
    write_d     = 1'b0;
    addr_d      = IDLE_ADDR;
    wbyte_d     = wbyte_q;
    rd_hi_d     = rd_hi_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    take_cmd    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          take_cmd = 1'b1;
          state_d  = S_ACC1;
          wbyte_d  = cmd_data_i[7:0];
          case (cmd_op_i)
            OP_WR_BYTE: begin write_d = 1'b1; addr_d = cmd_addr_i; end
            OP_RD_BYTE: begin read_d  = 1'b1; addr_d = cmd_addr_i; end
            OP_WR_DIV:  begin write_d = 1'b1; addr_d = LDVR_ADDR;  end
            default:    begin read_d  = 1'b1; addr_d = UDVR_ADDR;  end
          endcase
        end
      end
      S_ACC1: begin
        // Divisor reads go UDVR then LDVR so a read never forms the committing LDVR->UDVR pair.
        if (op_q[1]) begin
          state_d = S_ACC2;
          if (op_q == OP_WR_DIV) begin
            write_d = 1'b1;
            addr_d  = UDVR_ADDR;
            wbyte_d = data_hi_q;
          end else begin
            read_d  = 1'b1;
            addr_d  = LDVR_ADDR;
            rd_hi_d = data_io;
          end
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = (op_q == OP_RD_BYTE) ? {8'h00, data_io} : 16'h0000;
        end
      end
      S_ACC2: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = (op_q == OP_RD_DIV) ? {rd_hi_q, data_io} : 16'h0000;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign read_o      = read_q;
  assign write_o     = write_q;
  assign address_o   = addr_q;
  assign data_io     = write_q ? wbyte_q : 8'hzz;

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: a register-file model on the bus plus a transaction-level
// expectation model of register contents, RX/TX FIFOs and divisor commits.
`timescale 1ns/1ps
module tb_uart_bus_master;

  localparam logic [2:0] RXR  = 3'd0;
  localparam logic [2:0] STR  = 3'd1;
  localparam logic [2:0] LDVR = 3'd4;
  localparam logic [2:0] UDVR = 3'd5;
  localparam logic [2:0] IDLE = STR;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_addr = 3'd0;
  logic [15:0] cmd_data = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        read_o, write_o;
  logic [2:0]  address_o;
  wire  [7:0]  bus;

  always #5 clk = ~clk;

  uart_bus_master #(
    .STR_ADDR(STR), .LDVR_ADDR(LDVR), .UDVR_ADDR(UDVR), .IDLE_ADDR(IDLE)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .read_o(read_o), .write_o(write_o), .address_o(address_o), .data_io(bus)
  );

  // Register file on the far side of the bus
  logic [7:0]  rf_regs [8] = '{default: 8'h00};
  logic [7:0]  rx_mem [64];
  logic [5:0]  rx_rd = 6'd0;
  logic [7:0]  tx_mem [64];
  logic [5:0]  tx_wr = 6'd0;
  logic [15:0] rf_div = 16'h0;
  int          commit_cnt = 0;
  int          seq_cnt = 0;
  int          cyc = 0;
  logic        prev_ldvr_wr = 1'b0;
  logic        prev_ldvr_addr = 1'b0;
  logic [7:0]  rf_rdata;

  always_comb rf_rdata = (address_o == RXR) ? rx_mem[rx_rd] : rf_regs[address_o];
  assign bus = read_o ? rf_rdata : 8'hzz;

  always @(posedge clk) begin
    cyc            <= cyc + 1;
    prev_ldvr_wr   <= write_o && (address_o == LDVR);
    prev_ldvr_addr <= (address_o == LDVR);
    if (prev_ldvr_addr && address_o == UDVR) seq_cnt <= seq_cnt + 1;
    if (write_o) begin
      if (address_o == RXR) begin
        tx_mem[tx_wr] <= bus;
        tx_wr         <= tx_wr + 6'd1;
      end else begin
        rf_regs[address_o] <= bus;
      end
      if (prev_ldvr_wr && address_o == UDVR) begin
        rf_div     <= {bus, rf_regs[LDVR]};
        commit_cnt <= commit_cnt + 1;
      end
    end
    if (read_o && address_o == RXR) rx_rd <= rx_rd + 6'd1;
  end

  // Expectation model
  logic [7:0]  exp_regs [8];
  logic [7:0]  exp_tx [64];
  int          exp_txn = 0;
  int          exp_pops = 0;
  int          exp_commits = 0;
  logic [15:0] exp_div = 16'h0;
  int          hs_cyc = 0;
  int          vec = 0;
  int          err = 0;

  task automatic do_cmd(input logic [1:0] op, input logic [2:0] a, input logic [15:0] d,
                        input int hold, input string tag);
    logic [15:0] exp_rsp;
    int          n;
    logic        acc_rd [2];
    logic [2:0]  acc_a [2];
    logic [7:0]  acc_d [2];
    exp_rsp = 16'h0;
    n = 1;
    acc_rd[1] = 1'b0; acc_a[1] = IDLE; acc_d[1] = 8'h00;
    case (op)
      2'b00: begin
        acc_rd[0] = 1'b0; acc_a[0] = a; acc_d[0] = d[7:0];
        if (a == RXR) begin exp_tx[exp_txn] = d[7:0]; exp_txn++; end
        else exp_regs[a] = d[7:0];
      end
      2'b01: begin
        acc_rd[0] = 1'b1; acc_a[0] = a; acc_d[0] = 8'h00;
        if (a == RXR) begin exp_rsp = {8'h00, rx_mem[exp_pops[5:0]]}; exp_pops++; end
        else exp_rsp = {8'h00, exp_regs[a]};
      end
      2'b10: begin
        n = 2;
        acc_rd[0] = 1'b0; acc_a[0] = LDVR; acc_d[0] = d[7:0];
        acc_rd[1] = 1'b0; acc_a[1] = UDVR; acc_d[1] = d[15:8];
        exp_regs[LDVR] = d[7:0];
        exp_regs[UDVR] = d[15:8];
        exp_commits++;
        exp_div = d;
      end
      default: begin
        n = 2;
        acc_rd[0] = 1'b1; acc_a[0] = UDVR; acc_d[0] = 8'h00;
        acc_rd[1] = 1'b1; acc_a[1] = LDVR; acc_d[1] = 8'h00;
        exp_rsp = {exp_regs[UDVR], exp_regs[LDVR]};
      end
    endcase

    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; rsp_ready = 1'b0;
    vec++;
    if (cmd_ready !== 1'b1) begin
      err++; $display("FAIL %s idle_ready: got %b want 1", tag, cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    hs_cyc = cyc;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom_range(0, 3)); cmd_addr = 3'($urandom_range(0, 7)); cmd_data = 16'($urandom);

    for (int i = 0; i < n; i++) begin
      vec++;
      if ({read_o, write_o, address_o, cmd_ready, rsp_valid} !==
          {acc_rd[i], ~acc_rd[i], acc_a[i], 1'b0, 1'b0}) begin
        err++;
        $display("FAIL %s access%0d: got rd=%b wr=%b addr=%0d rdy=%b rv=%b want rd=%b wr=%b addr=%0d rdy=0 rv=0",
                 tag, i, read_o, write_o, address_o, cmd_ready, rsp_valid, acc_rd[i], ~acc_rd[i], acc_a[i]);
      end
      if (!acc_rd[i]) begin
        vec++;
        if (bus !== acc_d[i]) begin
          err++; $display("FAIL %s wdata%0d: got %02h want %02h", tag, i, bus, acc_d[i]);
        end
      end
      @(negedge clk);
    end

    for (int h = 0; h <= hold; h++) begin
      vec++;
      if ({rsp_valid, cmd_ready, read_o, write_o, address_o} !== {1'b1, 1'b0, 1'b0, 1'b0, IDLE}) begin
        err++;
        $display("FAIL %s resp_state[%0d]: got rv=%b rdy=%b rd=%b wr=%b addr=%0d want rv=1 rdy=0 rd=0 wr=0 addr=%0d",
                 tag, h, rsp_valid, cmd_ready, read_o, write_o, address_o, IDLE);
      end
      vec++;
      if (rsp_data !== exp_rsp) begin
        err++; $display("FAIL %s rsp_data[%0d]: got %04h want %04h", tag, h, rsp_data, exp_rsp);
      end
      if (h < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    vec++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      err++; $display("FAIL %s release: got rv=%b rdy=%b want rv=0 rdy=1", tag, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    vec++;
    if ({cmd_ready, rsp_valid, rsp_data, read_o, write_o, address_o} !==
        {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, IDLE}) begin
      err++;
      $display("FAIL reset_in: got rdy=%b rv=%b rd=%04h r=%b w=%b a=%0d", cmd_ready, rsp_valid, rsp_data, read_o, write_o, address_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if ({cmd_ready, rsp_valid, read_o, write_o, address_o} !== {1'b1, 1'b0, 1'b0, 1'b0, IDLE}) begin
      err++;
      $display("FAIL reset_out: got rdy=%b rv=%b r=%b w=%b a=%0d", cmd_ready, rsp_valid, read_o, write_o, address_o);
    end
  endtask

  task automatic test_str_write();
    do_cmd(2'b00, STR, 16'h002D, 0, "str_wr");
  endtask

  task automatic test_div_write();
    int c0;
    c0 = commit_cnt;
    do_cmd(2'b10, 3'($urandom_range(0, 7)), 16'h1458, 0, "div_wr");
    vec++;
    if (commit_cnt !== c0 + 1 || rf_div !== 16'h1458) begin
      err++; $display("FAIL div_commit: got cnt=%0d div=%04h want cnt=%0d div=1458", commit_cnt, rf_div, c0 + 1);
    end
  endtask

  task automatic test_div_read();
    int s0;
    s0 = seq_cnt;
    do_cmd(2'b11, 3'($urandom_range(0, 7)), 16'($urandom), 0, "div_rd");
    vec++;
    if (seq_cnt !== s0) begin
      err++; $display("FAIL div_rd_no_baud_reset: got %0d want %0d", seq_cnt, s0);
    end
  endtask

  task automatic test_rxr_backpressure();
    logic [5:0] p0;
    p0 = rx_rd;
    do_cmd(2'b01, RXR, 16'($urandom), 5, "rxr_bp");
    vec++;
    if (rx_rd !== p0 + 6'd1) begin
      err++; $display("FAIL rxr_pop: got %0d want %0d", rx_rd, p0 + 6'd1);
    end
  endtask

  task automatic test_back_to_back();
    int c0, s0, h1;
    c0 = commit_cnt; s0 = seq_cnt;
    do_cmd(2'b00, LDVR, 16'h0001, 0, "b2b_ldvr");
    h1 = hs_cyc;
    do_cmd(2'b00, UDVR, 16'h0000, 0, "b2b_udvr");
    vec++;
    if (hs_cyc - h1 !== 3) begin
      err++; $display("FAIL byte_period: got %0d want 3", hs_cyc - h1);
    end
    vec++;
    if (commit_cnt !== c0 || seq_cnt !== s0) begin
      err++; $display("FAIL b2b_no_commit: got cnt=%0d seq=%0d want cnt=%0d seq=%0d", commit_cnt, seq_cnt, c0, s0);
    end
    do_cmd(2'b11, 3'd0, 16'h0, 0, "b2b_drd0");
    h1 = hs_cyc;
    do_cmd(2'b11, 3'd0, 16'h0, 0, "b2b_drd1");
    vec++;
    if (hs_cyc - h1 !== 4) begin
      err++; $display("FAIL div_period: got %0d want 4", hs_cyc - h1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      do_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 16'($urandom),
             int'($urandom_range(0, 2)), "rand");
  endtask

  task automatic test_reset_mid();
    int c0;
    c0 = commit_cnt;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 3'd0; cmd_data = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    vec++;
    if ({write_o, address_o} !== {1'b1, LDVR}) begin
      err++; $display("FAIL rstmid_acc1: got w=%b a=%0d want w=1 a=%0d", write_o, address_o, LDVR);
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({cmd_ready, rsp_valid, rsp_data, read_o, write_o, address_o} !==
        {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, IDLE}) begin
      err++;
      $display("FAIL rstmid_async: got rdy=%b rv=%b rd=%04h r=%b w=%b a=%0d", cmd_ready, rsp_valid, rsp_data, read_o, write_o, address_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec++;
      if ({cmd_ready, read_o, write_o, address_o} !== {1'b1, 1'b0, 1'b0, IDLE}) begin
        err++;
        $display("FAIL rstmid_after[%0d]: got rdy=%b r=%b w=%b a=%0d", i, cmd_ready, read_o, write_o, address_o);
      end
    end
    vec++;
    if (commit_cnt !== c0) begin
      err++; $display("FAIL rstmid_no_commit: got %0d want %0d", commit_cnt, c0);
    end
    do_cmd(2'b11, 3'd0, 16'h0, 0, "rstmid_drd");
  endtask

  task automatic test_final_state();
    vec++;
    if (commit_cnt !== exp_commits || seq_cnt !== exp_commits || rf_div !== exp_div) begin
      err++;
      $display("FAIL final_div: got cnt=%0d seq=%0d div=%04h want cnt=%0d div=%04h", commit_cnt, seq_cnt, rf_div, exp_commits, exp_div);
    end
    vec++;
    if (rx_rd !== exp_pops[5:0] || tx_wr !== exp_txn[5:0]) begin
      err++; $display("FAIL final_fifo: got pops=%0d pushes=%0d want pops=%0d pushes=%0d", rx_rd, tx_wr, exp_pops, exp_txn);
    end
    for (int i = 0; i < exp_txn; i++) begin
      vec++;
      if (tx_mem[i] !== exp_tx[i]) begin
        err++; $display("FAIL final_tx[%0d]: got %02h want %02h", i, tx_mem[i], exp_tx[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rx_mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_str_write();
    test_div_write();
    test_div_read();
    test_rxr_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_final_state();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
